// File: rtl/cnn_buf_pkg.sv
// Shared types and constants for the per-lane CNN buffers: element/word widths,
// the pack-state encoding and the FIFO pointer-width helper.
package cnn_buf_pkg;
  localparam int ELEM_W = 16;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    EMPTY      = 2'd0,
    HALF       = 2'd1,
    FLUSH_WAIT = 2'd2
  } pack_state_e;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/packer_fifo.sv
// Synchronous word FIFO for the output packer: wrapping pointers, occupancy count,
// head word read combinationally from the storage array.
import cnn_buf_pkg::*;

module packer_fifo #(
  parameter int W     = WORD_W,
  parameter int DEPTH = 8,
  localparam int AW   = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_reg == FULL_CNT);
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_data = mem[rd_ptr_reg];
  assign count     = count_reg;
endmodule

// File: rtl/output_packer.sv
// Packs pairs of result elements into words and queues them for the AXI writer.
// Optional popped-word counter enabled with OUTPUT_PACKER_CNT_EN.
import cnn_buf_pkg::*;

module output_packer #(
  parameter int DATA_W = ELEM_W,
  parameter int DEPTH  = 8,
  localparam int AW    = ptr_width(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_vld,
  input  logic [DATA_W-1:0]   data_in,
  output logic                in_rdy,
  input  logic                flush,
  output logic [2*DATA_W-1:0] out_data,
  output logic                out_vld,
  input  logic                out_rdy,
  output logic                overflow,
  output logic                busy
`ifdef OUTPUT_PACKER_CNT_EN
  ,
  output logic [15:0]         word_cnt
`endif
);
  pack_state_e         state_reg, state_next;
  logic [DATA_W-1:0]   half_reg, half_next;
  logic                overflow_reg;
  logic                push;
  logic [2*DATA_W-1:0] push_data;
  logic [2*DATA_W-1:0] head_data;
  logic                fifo_full;
  logic                fifo_empty;
  logic [AW:0]         fifo_count;
  logic                accept;
  logic                pop;

  // Readiness uses registered occupancy only, so a same-cycle pop never frees a slot.
  assign in_rdy = (state_reg == EMPTY) || ((state_reg == HALF) && !fifo_full);
  assign accept = in_vld && in_rdy;
  assign pop    = out_rdy && !fifo_empty;

  always_comb begin
    state_next = state_reg;
    half_next  = half_reg;
    push       = 1'b0;
    push_data  = '0;
    case (state_reg)
      EMPTY: begin
        if (accept) begin
          half_next = data_in;
          if (!flush) begin
            state_next = HALF;
          end else if (!fifo_full) begin
            push      = 1'b1;
            push_data = {{DATA_W{1'b0}}, data_in};
          end else begin
            state_next = FLUSH_WAIT;
          end
        end
      end
      HALF: begin
        if (accept) begin
          push       = 1'b1;
          push_data  = {data_in, half_reg};
          state_next = EMPTY;
        end else if (flush) begin
          if (!fifo_full) begin
            push       = 1'b1;
            push_data  = {{DATA_W{1'b0}}, half_reg};
            state_next = EMPTY;
          end else begin
            state_next = FLUSH_WAIT;
          end
        end
      end
      FLUSH_WAIT: begin
        if (!fifo_full) begin
          push       = 1'b1;
          push_data  = {{DATA_W{1'b0}}, half_reg};
          state_next = EMPTY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= EMPTY;
      half_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      half_reg  <= half_next;
      if (in_vld && !in_rdy) overflow_reg <= 1'b1;
    end
  end

  packer_fifo #(
    .W     (2*DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_vld  = !fifo_empty;
  assign out_data = fifo_empty ? '0 : head_data;
  assign overflow = overflow_reg;
  assign busy     = (state_reg != EMPTY) || (fifo_count != '0);

`ifdef OUTPUT_PACKER_CNT_EN
  logic [15:0] word_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst)      word_cnt_reg <= '0;
    else if (pop) word_cnt_reg <= word_cnt_reg + 1'b1;
  end

  assign word_cnt = word_cnt_reg;
`endif
endmodule

// File: doc/output_packer.md
# output_packer

Write-back buffer for one output lane of the accelerator. Accepts a stream of 16-bit result elements from the processing array, packs consecutive pairs into 32-bit words, and queues them in a small FIFO. An AXI-side writer drains the FIFO with a valid/ready handshake. It is the transmit-direction counterpart of the per-lane input buffer, which unpacks 32-bit AXI words into 16-bit elements.

## Interface
- `DATA_W`, default 16: element width. Word width is 2*DATA_W.
- `DEPTH`, default 8: FIFO depth in words. Must be a power of 2, ≥2.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_vld` input 1: `data_in` carries a valid element this cycle.
- `data_in` input DATA_W: result element.
- `in_rdy` output 1: element accepted if `in_vld` is high this cycle.
- `flush` input 1: pad and push any held odd element.
- `out_data` output 2*DATA_W: head word, low half = earlier element.
- `out_vld` output 1: FIFO non-empty.
- `out_rdy` input 1: downstream pops the head word when `out_vld` is also high.
- `overflow` output 1: sticky flag, set when an element is offered while `in_rdy` is low.
- `busy` output 1: half held, FIFO non-empty, or flush pending.
- `word_cnt` output 16: popped-word counter. Present only with `OUTPUT_PACKER_CNT_EN`.

## Operation
- Pack FSM states:
  - `EMPTY`: no element held.
  - `HALF`: low half held in `half_reg`.
  - `FLUSH_WAIT`: flush requested with half held, FIFO full.
- Transitions:
  - `EMPTY` + accepted element → `HALF`. The element is latched into `half_reg`.
  - `HALF` + accepted element → `EMPTY`. Push `{data_in, half_reg}`.
  - `HALF` + `flush`, FIFO not full → `EMPTY`. Push `{0, half_reg}`.
  - `HALF` + `flush`, FIFO full → `FLUSH_WAIT`.
  - `FLUSH_WAIT`, FIFO not full → push `{0, half_reg}`, then `EMPTY`.
- `flush` in `EMPTY` with no element is a no-op.
- `flush` with an accepted element in the same cycle:
  - From `EMPTY`: push `{0, data_in}` and stay in `EMPTY`.
  - From `HALF`: push the pair; no pad word.
- At most one push per cycle.
- `in_rdy` = (state==`EMPTY`) or (state==`HALF` and FIFO not full). `in_rdy` is low in `FLUSH_WAIT`.
- `in_rdy` derives from registered state only. A push into a full FIFO is never permitted, even if a pop occurs in the same cycle.
- A rejected element (`in_vld` high, `in_rdy` low) is dropped and `overflow` is set. Only `rst` clears `overflow`.
- FIFO:
  - Separate read and write pointers of log2(DEPTH) bits, each wrapping at DEPTH.
  - Occupancy count of log2(DEPTH)+1 bits.
  - Push and pop in the same cycle leave the count unchanged.
- `out_data` shows mem[rd_ptr] when `out_vld` is high, and 0 when it is low.

## Timing
- Reset, on rising `clk` with `rst`=1:
  - State `EMPTY`, pointers and count 0, `half_reg` 0.
  - `out_vld`=0, `out_data`=0, `overflow`=0, `busy`=0, `in_rdy`=1, `word_cnt`=0.
- Reset mid-operation discards held and queued data with no drain.
- Latency: the completing element (or flush) accepted at cycle N gives `out_vld` high and the word on `out_data` at N+1.
- Pop at cycle N advances the head at N+1. Sustained throughput is one word per cycle out and one element per cycle in.
- `out_vld` and `out_data` hold stable while `out_rdy` is low.

## Configuration
- `OUTPUT_PACKER_CNT_EN` defined:
  - `word_cnt` increments on each pop and wraps at 2^16.
  - It clears on `rst`.
- Not defined:
  - Port and counter logic are absent.
  - All other behaviour is identical.

## Structure
- Package `cnn_buf_pkg`:
  - `ELEM_W`=16 and `WORD_W`=32.
  - Pack-state enum `pack_state_e` (`EMPTY`, `HALF`, `FLUSH_WAIT`).
  - Function `clog2`-based pointer width.
- Sub-module `packer_fifo`: synchronous FIFO with push/pop, full/empty, count.
- `output_packer` instantiates one `packer_fifo` and holds the FSM and `half_reg`.

## Test plan
- Pairing: `in_vld` with 0x1111 then 0x2222 → next cycle `out_vld`=1, `out_data`=0x2222_1111; pop with `out_rdy`=1 → `out_vld`=0, `out_data`=0.
- Odd flush: 0xAAAA, then `flush` → `out_data`=0x0000_AAAA. Also 0xBBBB with `flush` in the same cycle from `EMPTY` → 0x0000_BBBB.
- Backpressure, DEPTH=8, `out_rdy`=0, 18 elements offered:
  - 16 elements fill 8 words; element 17 is held; `in_rdy` goes low.
  - Element 18 is dropped and `overflow`=1.
  - After draining, words 0x0001_0000 … appear in order.
- Flush while full: full FIFO, half held, `flush` → `FLUSH_WAIT`, `busy`=1; one pop → pad word pushed next cycle, state `EMPTY`.
- Wrap and reset: 40 elements with `out_rdy` toggling every cycle → 20 words in order across two pointer wraps. Then `rst` mid-stream → all outputs at reset values, and a new pair emerges correctly.
- With `OUTPUT_PACKER_CNT_EN`: 5 pops → `word_cnt`=5; `rst` → 0.
